opb_register_bank_ppc2simulink: RTL and testbench

OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

---
 rtl/opb_register_bank_ppc2simulink.sv | 141 ++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: PPC writes words that appear on user_data_out,
// optionally double-buffered behind a commit register at word NUM_REGS.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000700,
    parameter logic [31:0] C_HIGHADDR   = 32'h010007FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          NUM_REGS     = 4,
    parameter int          C_SHADOW     = 0,
    parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [NUM_REGS*32-1:0]    user_data_out,
    output logic [NUM_REGS-1:0]       user_update
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ACK        = 2'd1;
    localparam logic [1:0] WAIT_DESEL = 2'd2;

    localparam logic [31:0] NREGS = 32'(NUM_REGS);

    logic [1:0]  state;
    logic [31:0] addr;
    logic [31:0] offset;
    logic [31:0] word_idx;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [31:0] rd_word;
    logic [31:0] rd_q;
    logic [3:0]  be;
    logic        in_window;
    logic        start;
    logic        hit_reg;
    logic        hit_commit;
    logic        hit_err;
    logic        do_write;
    logic        do_commit;
    logic        unused_bits;

    logic [31:0] live   [NUM_REGS];
    logic [31:0] shadow [NUM_REGS];

    // The OPB buses are big-endian; numeric copies make BE[0] cover bits 31:24
    // and DBus[31] (the commit trigger) land on bit 0.
    assign addr     = 32'(OPB_ABus);
    assign wdata    = 32'(OPB_DBus);
    assign be       = 4'(OPB_BE);
    assign wmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign offset   = addr - C_BASEADDR;
    assign word_idx = {2'b00, offset[31:2]};

    assign in_window  = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign start      = (state == IDLE) && OPB_select && in_window;
    assign hit_reg    = (word_idx < NREGS);
    assign hit_commit = (word_idx == NREGS);
    assign hit_err    = (word_idx > NREGS);
    assign do_write   = start && !OPB_RNW && hit_reg;
    assign do_commit  = start && !OPB_RNW && hit_commit && (C_SHADOW != 0) && wdata[0];

    assign unused_bits = ^{offset[1:0], OPB_seqAddr};

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (word_idx == 32'(r)) begin
                rd_word = (C_SHADOW != 0) ? shadow[r] : live[r];
            end
        end
    end

    // Everything the ACK cycle shows is registered on the start edge, which
    // gives the single-cycle latency and makes writes visible during ACK.
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state       <= IDLE;
            Sl_xferAck  <= 1'b0;
            Sl_errAck   <= 1'b0;
            rd_q        <= '0;
            user_update <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                live[r]   <= C_RESET_VAL;
                shadow[r] <= C_RESET_VAL;
            end
        end else begin
            Sl_xferAck  <= 1'b0;
            Sl_errAck   <= 1'b0;
            rd_q        <= '0;
            user_update <= '0;

            case (state)
                IDLE:       if (start) state <= ACK;
                ACK:        state <= WAIT_DESEL;
                WAIT_DESEL: if (!OPB_select) state <= IDLE;
                default:    state <= IDLE;
            endcase

            if (start) begin
                Sl_xferAck <= !hit_err;
                Sl_errAck  <= hit_err;
                if (OPB_RNW && hit_reg) rd_q <= rd_word;
            end

            for (int r = 0; r < NUM_REGS; r++) begin
                if (do_write && (word_idx == 32'(r))) begin
                    if (C_SHADOW != 0) begin
                        shadow[r] <= (shadow[r] & ~wmask) | (wdata & wmask);
                    end else begin
                        live[r]        <= (live[r] & ~wmask) | (wdata & wmask);
                        user_update[r] <= 1'b1;
                    end
                end
                if (do_commit) begin
                    live[r]        <= shadow[r];
                    user_update[r] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = live[g];
    end

    assign Sl_DBus    = C_OPB_DWIDTH'(rd_q);
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench: dut0 is the immediate-update bank, dut1 the double-buffered one,
// both driven from the same OPB bus.
module tb_opb_register_bank_ppc2simulink;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:31]  abus;
    logic [0:3]   be;
    logic [0:31]  dbus;
    logic         rnw;
    logic         sel;
    logic         seq;

    logic [0:31]  s0_dbus, s1_dbus;
    logic         s0_xack, s1_xack, s0_eack, s1_eack;
    logic         s0_retry, s1_retry, s0_tout, s1_tout;
    logic [127:0] udo0, udo1;
    logic [3:0]   upd0, upd1;

    int checks   = 0;
    int failures = 0;

    logic         a_xack0, a_eack0, a_xack1, a_eack1;
    logic [31:0]  a_dbus0, a_dbus1;
    logic [3:0]   a_upd0, a_upd1;
    logic [127:0] a_udo0, a_udo1;
    logic         n_xack0, n_eack0;
    logic [31:0]  n_dbus0;
    logic [3:0]   n_upd0, n_upd1;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(.NUM_REGS(4), .C_SHADOW(0)) dut0 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(s0_dbus), .Sl_xferAck(s0_xack), .Sl_errAck(s0_eack),
        .Sl_retry(s0_retry), .Sl_toutSup(s0_tout),
        .user_data_out(udo0), .user_update(upd0)
    );

    opb_register_bank_ppc2simulink #(.NUM_REGS(4), .C_SHADOW(1)) dut1 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(s1_dbus), .Sl_xferAck(s1_xack), .Sl_errAck(s1_eack),
        .Sl_retry(s1_retry), .Sl_toutSup(s1_tout),
        .user_data_out(udo1), .user_update(upd1)
    );

    typedef struct {
        logic         rnw;
        logic [31:0]  addr;
        logic [3:0]   be;
        logic [31:0]  data;
        logic         exp_xack;
        logic         exp_eack;
        logic [31:0]  exp_rd;
        logic [3:0]   exp_upd;
        logic [127:0] exp_udo;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One complete OPB transfer: select for the start cycle, then drop it
    // during ACK and let the slave return to idle.
    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        rnw = r; abus = a; be = b; dbus = d; sel = 1'b1;
        @(posedge clk); #1;
        a_xack0 = s0_xack; a_eack0 = s0_eack; a_dbus0 = s0_dbus; a_upd0 = upd0; a_udo0 = udo0;
        a_xack1 = s1_xack; a_eack1 = s1_eack; a_dbus1 = s1_dbus; a_upd1 = upd1; a_udo1 = udo1;
        @(negedge clk);
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0;
        @(posedge clk); #1;
        n_xack0 = s0_xack; n_eack0 = s0_eack; n_dbus0 = s0_dbus; n_upd0 = upd0; n_upd1 = upd1;
        @(posedge clk);
    endtask

    localparam logic [127:0] U1 = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    localparam logic [127:0] U3 = {32'h0, 32'hDEADBEEF, 32'h00003344, 32'h0};
    localparam logic [127:0] U5 = {32'h0, 32'hCAADBEEF, 32'h00003344, 32'h0};
    localparam logic [127:0] U7 = {32'h00AA5500, 32'hCAADBEEF, 32'h00003344, 32'h0};

    initial begin
        int acks;

        vecs[0]  = '{1'b0, 32'h01000708, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        4'b0100, U1};
        vecs[1]  = '{1'b1, 32'h01000708, 4'b1111, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 4'b0000, U1};
        vecs[2]  = '{1'b0, 32'h01000704, 4'b0011, 32'h11223344, 1'b1, 1'b0, 32'h0,        4'b0010, U3};
        vecs[3]  = '{1'b1, 32'h01000704, 4'b1111, 32'h0,        1'b1, 1'b0, 32'h00003344, 4'b0000, U3};
        vecs[4]  = '{1'b0, 32'h01000708, 4'b1000, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        4'b0100, U5};
        vecs[5]  = '{1'b0, 32'h01000700, 4'b0000, 32'h12345678, 1'b1, 1'b0, 32'h0,        4'b0001, U5};
        vecs[6]  = '{1'b0, 32'h0100070C, 4'b0110, 32'h55AA55AA, 1'b1, 1'b0, 32'h0,        4'b1000, U7};
        vecs[7]  = '{1'b1, 32'h0100070B, 4'b1111, 32'h0,        1'b1, 1'b0, 32'hCAADBEEF, 4'b0000, U7};
        vecs[8]  = '{1'b1, 32'h01000710, 4'b1111, 32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, U7};
        vecs[9]  = '{1'b0, 32'h01000710, 4'b1111, 32'h1,        1'b1, 1'b0, 32'h0,        4'b0000, U7};
        vecs[10] = '{1'b0, 32'h01000718, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        4'b0000, U7};
        vecs[11] = '{1'b1, 32'h01000718, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, U7};
        vecs[12] = '{1'b1, 32'h010007FC, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, U7};
        vecs[13] = '{1'b0, 32'h010006FC, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        4'b0000, U7};
        vecs[14] = '{1'b0, 32'h01000800, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        4'b0000, U7};
        vecs[15] = '{1'b1, 32'h0100070C, 4'b1111, 32'h0,        1'b1, 1'b0, 32'h00AA5500, 4'b0000, U7};

        rst_n = 1'b0; sel = 1'b0; rnw = 1'b0; seq = 1'b0;
        abus = '0; be = '0; dbus = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_xack", 128'(s0_xack), 128'(0));
        checkOutput("reset_eack", 128'(s0_eack), 128'(0));
        checkOutput("reset_dbus", 128'(s0_dbus), 128'(0));
        checkOutput("reset_upd",  128'(upd0), 128'(0));
        checkOutput("reset_udo0", udo0, 128'(0));
        checkOutput("reset_udo1", udo1, 128'(0));
        checkOutput("retry_tout", 128'({s0_retry, s0_tout, s1_retry, s1_tout}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rnw, vecs[i].addr, vecs[i].be, vecs[i].data);
            checkOutput($sformatf("v%0d_xack", i), 128'(a_xack0), 128'(vecs[i].exp_xack));
            checkOutput($sformatf("v%0d_eack", i), 128'(a_eack0), 128'(vecs[i].exp_eack));
            checkOutput($sformatf("v%0d_rd", i),   128'(a_dbus0), 128'(vecs[i].exp_rd));
            checkOutput($sformatf("v%0d_upd", i),  128'(a_upd0),  128'(vecs[i].exp_upd));
            checkOutput($sformatf("v%0d_udo", i),  a_udo0, vecs[i].exp_udo);
            checkOutput($sformatf("v%0d_after", i), 128'({n_xack0, n_eack0, n_upd0, n_dbus0}), 128'(0));
        end

        // Select held for five cycles must yield a single acknowledge.
        acks = 0;
        @(negedge clk);
        rnw = 1'b1; abus = 32'h01000700; be = 4'hF; sel = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) checkOutput("held_first_ack", 128'(s0_xack), 128'(1));
            if (s0_xack || s0_eack) acks++;
        end
        @(negedge clk);
        sel = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (s0_xack || s0_eack) acks++;
        end
        checkOutput("held_ack_count", 128'(acks), 128'(1));

        // Reset during the start cycle drops it; select still high afterwards restarts.
        @(negedge clk);
        rst_n = 1'b0; sel = 1'b1; rnw = 1'b0; abus = 32'h01000700; be = 4'hF; dbus = 32'h11111111;
        @(posedge clk); #1;
        checkOutput("rstmid_acks", 128'({s0_xack, s0_eack, s1_xack, s1_eack}), 128'(0));
        checkOutput("rstmid_dbus_upd", 128'({s0_dbus, upd0, upd1}), 128'(0));
        checkOutput("rstmid_udo0", udo0, 128'(0));
        checkOutput("rstmid_udo1", udo1, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("restart_xack", 128'(s0_xack), 128'(1));
        checkOutput("restart_udo0", udo0, {96'h0, 32'h11111111});
        checkOutput("restart_upd0", 128'(upd0), 128'(4'b0001));
        checkOutput("restart_udo1", udo1, 128'(0));
        @(negedge clk);
        sel = 1'b0; dbus = '0;
        repeat (2) @(posedge clk);

        // Double-buffered bank: shadow write, no-op commit, then real commit.
        applyStimulus(1'b0, 32'h01000700, 4'hF, 32'hA5A5A5A5);
        checkOutput("sh_wr_xack", 128'(a_xack1), 128'(1));
        checkOutput("sh_wr_live", 128'(a_udo1[31:0]), 128'(0));
        applyStimulus(1'b1, 32'h01000700, 4'hF, 32'h0);
        checkOutput("sh_rd_shadow", 128'(a_dbus1), 128'(32'hA5A5A5A5));
        checkOutput("sh_rd_live", 128'(a_udo1[31:0]), 128'(0));
        applyStimulus(1'b0, 32'h01000710, 4'hF, 32'h0);
        checkOutput("sh_commit0_xack", 128'(a_xack1), 128'(1));
        checkOutput("sh_commit0_live", 128'(a_udo1[31:0]), 128'(0));
        checkOutput("sh_commit0_upd", 128'(a_upd1), 128'(0));
        applyStimulus(1'b0, 32'h01000710, 4'hF, 32'h1);
        checkOutput("sh_commit_live0", 128'(a_udo1[31:0]), 128'(32'hA5A5A5A5));
        checkOutput("sh_commit_live1", 128'(a_udo1[63:32]), 128'(0));
        checkOutput("sh_commit_upd", 128'(a_upd1), 128'(4'b1111));
        checkOutput("sh_commit_upd_after", 128'(n_upd1), 128'(0));
        checkOutput("imm_commit_noop", 128'(a_upd0), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
